drive_sequencer: RTL and testbench

Command-driven motion sequencer that sits directly upstream of the servo motor driver. It buffers a short list of motion segments, each a direction code plus a duration in ticks. On `start` it plays them back in order on the 2-bit `dir` bus the driver consumes (00 stop, 01 forward, 10 reverse). It replaces hard-coded location offsets with a loadable, abortable route.

---
 rtl/drive_sequencer_if.sv | 28 ++
 rtl/drive_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_drive_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/drive_sequencer_if.sv
// Command load and playback bus between a route loader (master) and drive_sequencer (slave).
interface drive_sequencer_if #(
    parameter int DEPTH = 4,
    parameter int DUR_W = 10
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_dir;
    logic [DUR_W-1:0] cmd_dur;
    logic             start;
    logic             abort;
    logic [1:0]       dir;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output cmd_valid, cmd_dir, cmd_dur, start, abort,
        input  cmd_ready, dir, busy, done, fifo_count
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_dur, start, abort,
        output cmd_ready, dir, busy, done, fifo_count
    );
endinterface

// File: rtl/drive_sequencer.sv
// Buffers {dir, duration} motion segments and plays them back on a registered 2-bit dir bus.
// Optional SEQ_GUARD_EN inserts a GUARD_TICKS stop gap before every direction reversal.
module drive_sequencer #(
    parameter int TICK_DIV    = 100_000,
    parameter int DEPTH       = 4,
    parameter int DUR_W       = 10,
    parameter int GUARD_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    drive_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PS_W  = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (TICK_DIV < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GUARD_TICKS < 0) begin : g_param_check
        $error("drive_sequencer: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GUARD, S_DONE} state_t;

    typedef struct packed {
        logic [1:0]       dir;
        logic [DUR_W-1:0] dur;
    } cmd_t;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             full;
    logic             push;
    logic             pop;
    cmd_t             head;
    logic [1:0]       head_dir;

    state_t           state;
    logic [1:0]       cur_dir;
    logic [DUR_W-1:0] remaining;
    logic [PS_W-1:0]  presc;
    logic             wrap;

    assign full          = (count == FULL_CNT);
    assign bus.cmd_ready = !full && !bus.abort;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == S_LOAD);
    assign head          = mem[rd_ptr];
    assign head_dir      = (head.dir == 2'b11) ? 2'b00 : head.dir;
    assign wrap          = (presc == PS_LAST);
    assign bus.fifo_count = count;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{dir: bus.cmd_dir, dur: bus.cmd_dur};
        end
    end

`ifdef SEQ_GUARD_EN
    localparam int GC_W = $clog2(GUARD_TICKS * TICK_DIV);
    localparam logic [GC_W-1:0] GUARD_LAST = GC_W'(GUARD_TICKS * TICK_DIV - 1);

    logic [1:0]      last_dir;
    logic [GC_W-1:0] guard_cnt;
    logic            reversal;

    assign reversal = (head_dir != 2'b00) && (last_dir != 2'b00) && (head_dir != last_dir);
`endif

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            state     <= S_IDLE;
            bus.dir   <= 2'b00;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cur_dir   <= 2'b00;
            remaining <= '0;
            presc     <= '0;
`ifdef SEQ_GUARD_EN
            last_dir  <= 2'b00;
            guard_cnt <= '0;
`endif
        end else begin
            count    <= count_nxt;
            bus.done <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case (state)
                S_IDLE: begin
                    bus.dir <= 2'b00;
`ifdef SEQ_GUARD_EN
                    last_dir <= 2'b00;
`endif
                    if (bus.start && count != '0) begin
                        state    <= S_LOAD;
                        bus.busy <= 1'b1;
                    end
                end

                S_LOAD: begin
                    presc     <= '0;
                    cur_dir   <= head_dir;
                    remaining <= head.dur;
                    if (head.dur == '0) begin
                        // Zero-length segment: consume it and look at the next head.
                        if (count_nxt != '0) begin
                            state <= S_LOAD;
                        end else begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end
                    end else begin
`ifdef SEQ_GUARD_EN
                        last_dir <= head_dir;
                        if (reversal) begin
                            state     <= S_GUARD;
                            guard_cnt <= GUARD_LAST;
                        end else begin
                            state   <= S_RUN;
                            bus.dir <= head_dir;
                        end
`else
                        state   <= S_RUN;
                        bus.dir <= head_dir;
`endif
                    end
                end

                S_RUN: begin
                    if (wrap) begin
                        presc <= '0;
                        if (remaining == DUR_W'(1)) begin
                            bus.dir <= 2'b00;
                            if (count_nxt != '0) begin
                                state <= S_LOAD;
                            end else begin
                                state    <= S_DONE;
                                bus.done <= 1'b1;
                            end
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end

`ifdef SEQ_GUARD_EN
                S_GUARD: begin
                    if (guard_cnt == '0) begin
                        state   <= S_RUN;
                        bus.dir <= cur_dir;
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end
`endif

                S_DONE: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                    bus.dir  <= 2'b00;
                end

                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                    bus.dir  <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with TICK_DIV=4, DEPTH=4; expectations follow SEQ_GUARD_EN when defined.
module tb_drive_sequencer;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 4;
    localparam int DUR_W    = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [1:0] dir_tr  [64];
    logic       busy_tr [64];
    logic       done_tr [64];
    int         cnt_tr  [64];

    drive_sequencer_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();

    drive_sequencer #(
        .TICK_DIV(TICK_DIV), .DEPTH(DEPTH), .DUR_W(DUR_W), .GUARD_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cmd_dir;
        int         dur;
        logic [1:0] exp_dir;
        int         exp_done;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_dir_range(input string name, input int first, input int last, input int exp);
        int bad_at = -1;
        for (int e = first; e <= last; e++) begin
            if (bad_at < 0 && int'(dir_tr[e]) != exp) bad_at = e;
        end
        total++;
        if (bad_at >= 0) begin
            bad++;
            $display("FAIL %s: dir at edge %0d got %0d expected %0d", name, bad_at, dir_tr[bad_at], exp);
        end
    endtask

    task automatic chk_busy_range(input string name, input int first, input int last, input int exp);
        int bad_at = -1;
        for (int e = first; e <= last; e++) begin
            if (bad_at < 0 && int'(busy_tr[e]) != exp) bad_at = e;
        end
        total++;
        if (bad_at >= 0) begin
            bad++;
            $display("FAIL %s: busy at edge %0d got %0d expected %0d", name, bad_at, busy_tr[bad_at], exp);
        end
    endtask

    // Called at a negedge; records the value seen after each of the next n edges.
    task automatic capture(input int n);
        for (int e = 1; e <= n; e++) begin
            @(negedge clk);
            bus.start = 1'b0;
            dir_tr[e]  = bus.dir;
            busy_tr[e] = bus.busy;
            done_tr[e] = bus.done;
            cnt_tr[e]  = int'(bus.fifo_count);
        end
    endtask

    function automatic int first_done(input int n);
        for (int e = 1; e <= n; e++) begin
            if (done_tr[e]) return e;
        end
        return -1;
    endfunction

    function automatic int done_pulses(input int n);
        int c = 0;
        for (int e = 1; e <= n; e++) c += int'(done_tr[e]);
        return c;
    endfunction

    task automatic push_cmd(input logic [1:0] d, input int dur);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = d;
        bus.cmd_dur   = DUR_W'(dur);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        vec_t vecs [5];
        int   d;
        vecs[0] = '{2'b01, 1, 2'b01, 6};
        vecs[1] = '{2'b10, 2, 2'b10, 10};
        vecs[2] = '{2'b11, 1, 2'b00, 6};
        vecs[3] = '{2'b00, 2, 2'b00, 10};
        vecs[4] = '{2'b01, 3, 2'b01, 14};

        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 2'b00;
        bus.cmd_dur   = '0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_dir", int'(bus.dir), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_count", int'(bus.fifo_count), 0);
        chk("reset_ready", int'(bus.cmd_ready), 1);

        // Single-segment table: run length, done timing and dir 11 -> 00.
        foreach (vecs[i]) begin
            d = vecs[i].dur;
            push_cmd(vecs[i].cmd_dir, d);
            chk($sformatf("vec%0d_count", i), int'(bus.fifo_count), 1);
            bus.start = 1'b1;
            capture(4 * d + 4);
            chk_dir_range($sformatf("vec%0d_dir", i), 2, 1 + 4 * d, int'(vecs[i].exp_dir));
            chk($sformatf("vec%0d_done_edge", i), first_done(4 * d + 4), vecs[i].exp_done);
            chk($sformatf("vec%0d_busy_after", i), int'(busy_tr[vecs[i].exp_done + 1]), 0);
            chk($sformatf("vec%0d_count_after", i), cnt_tr[2], 0);
        end

        // Two segments with a reversal.
        push_cmd(2'b01, 3);
        push_cmd(2'b10, 2);
        bus.start = 1'b1;
        capture(40);
        chk_dir_range("two_seg_first", 2, 13, 1);
        chk_dir_range("two_seg_load", 14, 14, 0);
`ifdef SEQ_GUARD_EN
        chk_dir_range("two_seg_guard", 15, 22, 0);
        chk_dir_range("two_seg_second", 23, 30, 2);
        chk("two_seg_done_edge", first_done(40), 31);
        chk_busy_range("two_seg_busy", 1, 31, 1);
        chk("two_seg_busy_low", int'(busy_tr[32]), 0);
`else
        chk_dir_range("two_seg_second", 15, 22, 2);
        chk("two_seg_done_edge", first_done(40), 23);
        chk_busy_range("two_seg_busy", 1, 23, 1);
        chk("two_seg_busy_low", int'(busy_tr[24]), 0);
`endif
        chk("two_seg_done_pulses", done_pulses(40), 1);

        // Fill the FIFO; a fifth command waits until the first LOAD pop.
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = 2'b01;
        bus.cmd_dur   = DUR_W'(1);
        repeat (4) @(negedge clk);
        bus.cmd_dir   = 2'b10;
        chk("full_count", int'(bus.fifo_count), 4);
        chk("full_ready", int'(bus.cmd_ready), 0);
        repeat (3) @(negedge clk);
        chk("full_hold_count", int'(bus.fifo_count), 4);
        bus.start = 1'b1;
        capture(3);
        bus.cmd_valid = 1'b0;
        chk("full_count_in_load", cnt_tr[1], 4);
        chk("full_count_after_pop", cnt_tr[2], 3);
        chk("full_fifth_accepted", cnt_tr[3], 4);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("full_abort_count", int'(bus.fifo_count), 0);
        chk("full_abort_busy", int'(bus.busy), 0);

        // Abort mid-RUN, with a push attempted in the abort cycle.
        push_cmd(2'b01, 5);
        bus.start = 1'b1;
        capture(7);
        chk("abort_dir_before", int'(bus.dir), 1);
        bus.abort     = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = 2'b10;
        #1;
        chk("abort_ready_low", int'(bus.cmd_ready), 0);
        @(negedge clk);
        bus.abort     = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("abort_dir", int'(bus.dir), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_count", int'(bus.fifo_count), 0);
        capture(30);
        chk("abort_no_done", done_pulses(30), 0);
        chk_busy_range("abort_stays_idle", 1, 30, 0);

        // Zero-duration skip followed by a one-tick segment.
        push_cmd(2'b00, 0);
        push_cmd(2'b01, 1);
        bus.start = 1'b1;
        capture(12);
        chk_dir_range("skip_load_gap", 1, 2, 0);
        chk_dir_range("skip_run", 3, 6, 1);
        chk("skip_dir_after", int'(dir_tr[7]), 0);
        chk("skip_done_edge", first_done(12), 7);

        // Start with an empty FIFO is ignored.
        bus.start = 1'b1;
        capture(4);
        chk_busy_range("empty_start_busy", 1, 4, 0);
        chk("empty_start_count", cnt_tr[4], 0);

        // Reset in the middle of playback.
        push_cmd(2'b10, 3);
        bus.start = 1'b1;
        capture(5);
        chk("rst_mid_dir_before", int'(bus.dir), 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_dir", int'(bus.dir), 0);
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_done", int'(bus.done), 0);
        chk("rst_mid_count", int'(bus.fifo_count), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", int'(bus.cmd_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
